// File: rtl/bellek_hakem.sv
`default_nettype none
// ============================================================================
//  Module   : bellek_hakem
//  Purpose  : Single-port memory arbiter/sequencer between the fetch stage
//             (getir) and the load/store stage (veri). One request is served
//             at a time; the shared bellek_* port drives main memory.
//  Ports    : clk, rst                       - clock, async active-high reset
//             getir_istek/adres              - fetch request in
//             getir_hazir                    - fetch accepted (comb., BOSTA)
//             getir_gecerli/veri/hata        - fetch response (registered)
//             veri_istek/yaz/adres/yaz_veri  - load/store request in
//             veri_hazir                     - load/store accepted (comb.)
//             veri_gecerli/oku_veri/hata     - load/store response (registered)
//             bellek_adres/yaz_veri/yaz      - memory port out (registered)
//             bellek_oku_veri                - memory read data in
//  Revision : 1.0 - initial release
// ============================================================================
module bellek_hakem #(
    parameter int                   VERI_BIT      = 32,
    parameter int                   ADRES_BIT     = 32,
    parameter logic [ADRES_BIT-1:0] BELLEK_TABAN  = 32'h8000_0000,
    parameter logic [ADRES_BIT-1:0] BELLEK_BOYUT  = 32'h0001_0000,
    parameter int                   OKUMA_GECIKME = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 getir_istek,
    input  logic [ADRES_BIT-1:0] getir_adres,
    output logic                 getir_hazir,
    output logic                 getir_gecerli,
    output logic [VERI_BIT-1:0]  getir_veri,
    output logic                 getir_hata,
    input  logic                 veri_istek,
    input  logic                 veri_yaz,
    input  logic [ADRES_BIT-1:0] veri_adres,
    input  logic [VERI_BIT-1:0]  veri_yaz_veri,
    output logic                 veri_hazir,
    output logic                 veri_gecerli,
    output logic [VERI_BIT-1:0]  veri_oku_veri,
    output logic                 veri_hata,
    output logic [ADRES_BIT-1:0] bellek_adres,
    input  logic [VERI_BIT-1:0]  bellek_oku_veri,
    output logic [VERI_BIT-1:0]  bellek_yaz_veri,
    output logic                 bellek_yaz
);

    typedef enum logic [2:0] {
        BOSTA      = 3'd0,
        OKU        = 3'd1,
        YAZ        = 3'd2,
        YANIT      = 3'd3,
        HATA_YANIT = 3'd4
    } durum_e;

    localparam logic GETIR = 1'b0;
    localparam logic VERI  = 1'b1;

    // Counter loads with (latency - 1); the read data is sampled when it hits 0.
    localparam logic [1:0] SAYAC_BAS = 2'(OKUMA_GECIKME - 1);

    // One extra bit so BELLEK_TABAN + BELLEK_BOYUT cannot wrap.
    localparam logic [ADRES_BIT:0] TABAN_GENIS = {1'b0, BELLEK_TABAN};
    localparam logic [ADRES_BIT:0] SON_GENIS   = {1'b0, BELLEK_TABAN} + {1'b0, BELLEK_BOYUT};

    durum_e                 durum_q, durum_d;
    logic                   son_kazanan_q, son_kazanan_d;
    logic                   sahip_q, sahip_d;
    logic [1:0]             sayac_q, sayac_d;
    logic [ADRES_BIT-1:0]   bellek_adres_q, bellek_adres_d;
    logic [VERI_BIT-1:0]    bellek_yaz_veri_q, bellek_yaz_veri_d;
    logic                   bellek_yaz_q, bellek_yaz_d;
    logic                   getir_gecerli_q, getir_gecerli_d;
    logic [VERI_BIT-1:0]    getir_veri_q, getir_veri_d;
    logic                   getir_hata_q, getir_hata_d;
    logic                   veri_gecerli_q, veri_gecerli_d;
    logic [VERI_BIT-1:0]    veri_oku_veri_q, veri_oku_veri_d;
    logic                   veri_hata_q, veri_hata_d;

    logic                   w_getir_kazanir;
    logic                   w_veri_kazanir;
    logic [ADRES_BIT-1:0]   w_sec_adres;
    logic [ADRES_BIT:0]     w_adres_genis;
    logic                   w_sec_yaz;
    logic                   w_hata;

    // Round robin: on a tie the requester that did not win last time goes.
    assign w_getir_kazanir = (durum_q == BOSTA) && getir_istek &&
                             (!veri_istek || (son_kazanan_q == VERI));
    assign w_veri_kazanir  = (durum_q == BOSTA) && veri_istek &&
                             (!getir_istek || (son_kazanan_q == GETIR));

    assign w_sec_adres   = w_veri_kazanir ? veri_adres : getir_adres;
    assign w_sec_yaz     = w_veri_kazanir && veri_yaz;
    assign w_adres_genis = {1'b0, w_sec_adres};
    assign w_hata        = (w_sec_adres[1:0] != 2'b00) ||
                           (w_adres_genis < TABAN_GENIS) ||
                           (w_adres_genis >= SON_GENIS);

    always_comb begin
        durum_d           = durum_q;
        son_kazanan_d     = son_kazanan_q;
        sahip_d           = sahip_q;
        sayac_d           = sayac_q;
        bellek_adres_d    = bellek_adres_q;
        bellek_yaz_veri_d = bellek_yaz_veri_q;
        bellek_yaz_d      = 1'b0;
        getir_gecerli_d   = 1'b0;
        getir_veri_d      = '0;
        getir_hata_d      = 1'b0;
        veri_gecerli_d    = 1'b0;
        veri_oku_veri_d   = '0;
        veri_hata_d       = 1'b0;

        case (durum_q)
            BOSTA: begin
                if (w_getir_kazanir || w_veri_kazanir) begin
                    son_kazanan_d = w_veri_kazanir;
                    sahip_d       = w_veri_kazanir;
                    if (w_hata) begin
                        // Error response is issued straight away; memory port untouched.
                        durum_d        = HATA_YANIT;
                        getir_gecerli_d = w_getir_kazanir;
                        getir_hata_d    = w_getir_kazanir;
                        veri_gecerli_d  = w_veri_kazanir;
                        veri_hata_d     = w_veri_kazanir;
                    end else if (w_sec_yaz) begin
                        durum_d           = YAZ;
                        bellek_adres_d    = w_sec_adres;
                        bellek_yaz_veri_d = veri_yaz_veri;
                        bellek_yaz_d      = 1'b1;
                    end else begin
                        durum_d        = OKU;
                        bellek_adres_d = w_sec_adres;
                        sayac_d        = SAYAC_BAS;
                    end
                end
            end
            OKU: begin
                if (sayac_q == 2'd0) begin
                    // Last hold cycle: memory data is valid, capture as response.
                    durum_d = YANIT;
                    if (sahip_q == VERI) begin
                        veri_gecerli_d  = 1'b1;
                        veri_oku_veri_d = bellek_oku_veri;
                    end else begin
                        getir_gecerli_d = 1'b1;
                        getir_veri_d    = bellek_oku_veri;
                    end
                end else begin
                    sayac_d = sayac_q - 2'd1;
                end
            end
            YAZ: begin
                durum_d         = YANIT;
                veri_gecerli_d  = (sahip_q == VERI);
                getir_gecerli_d = (sahip_q == GETIR);
            end
            YANIT:      durum_d = BOSTA;
            HATA_YANIT: durum_d = BOSTA;
            default:    durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q           <= BOSTA;
            son_kazanan_q     <= GETIR;
            sahip_q           <= GETIR;
            sayac_q           <= 2'd0;
            bellek_adres_q    <= '0;
            bellek_yaz_veri_q <= '0;
            bellek_yaz_q      <= 1'b0;
            getir_gecerli_q   <= 1'b0;
            getir_veri_q      <= '0;
            getir_hata_q      <= 1'b0;
            veri_gecerli_q    <= 1'b0;
            veri_oku_veri_q   <= '0;
            veri_hata_q       <= 1'b0;
        end else begin
            durum_q           <= durum_d;
            son_kazanan_q     <= son_kazanan_d;
            sahip_q           <= sahip_d;
            sayac_q           <= sayac_d;
            bellek_adres_q    <= bellek_adres_d;
            bellek_yaz_veri_q <= bellek_yaz_veri_d;
            bellek_yaz_q      <= bellek_yaz_d;
            getir_gecerli_q   <= getir_gecerli_d;
            getir_veri_q      <= getir_veri_d;
            getir_hata_q      <= getir_hata_d;
            veri_gecerli_q    <= veri_gecerli_d;
            veri_oku_veri_q   <= veri_oku_veri_d;
            veri_hata_q       <= veri_hata_d;
        end
    end

    assign getir_hazir     = w_getir_kazanir;
    assign veri_hazir      = w_veri_kazanir;
    assign getir_gecerli   = getir_gecerli_q;
    assign getir_veri      = getir_veri_q;
    assign getir_hata      = getir_hata_q;
    assign veri_gecerli    = veri_gecerli_q;
    assign veri_oku_veri   = veri_oku_veri_q;
    assign veri_hata       = veri_hata_q;
    assign bellek_adres    = bellek_adres_q;
    assign bellek_yaz_veri = bellek_yaz_veri_q;
    assign bellek_yaz      = bellek_yaz_q;

endmodule
`default_nettype wire

// File: tb/tb_bellek_hakem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bellek_hakem
//  Purpose  : Self-checking bench for bellek_hakem: a table of single
//             transactions plus hand sequences for arbitration, read latency 3
//             and reset during YAZ/OKU.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bellek_hakem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        getir_istek, getir_hazir, getir_gecerli, getir_hata;
    logic [31:0] getir_adres, getir_veri;
    logic        veri_istek, veri_yaz, veri_hazir, veri_gecerli, veri_hata;
    logic [31:0] veri_adres, veri_yaz_veri, veri_oku_veri;
    logic [31:0] bellek_adres, bellek_oku_veri, bellek_yaz_veri;
    logic        bellek_yaz;

    // Second instance with read latency 3
    logic        g3_getir_istek, g3_getir_hazir, g3_getir_gecerli, g3_getir_hata;
    logic [31:0] g3_getir_adres, g3_getir_veri;
    logic        g3_veri_istek, g3_veri_yaz, g3_veri_hazir, g3_veri_gecerli, g3_veri_hata;
    logic [31:0] g3_veri_adres, g3_veri_yaz_veri, g3_veri_oku_veri;
    logic [31:0] g3_bellek_adres, g3_bellek_oku_veri, g3_bellek_yaz_veri;
    logic        g3_bellek_yaz;

    int n_chk  = 0;
    int n_fail = 0;

    bellek_hakem #(.OKUMA_GECIKME(1)) dut (
        .clk(clk), .rst(rst),
        .getir_istek(getir_istek), .getir_adres(getir_adres), .getir_hazir(getir_hazir),
        .getir_gecerli(getir_gecerli), .getir_veri(getir_veri), .getir_hata(getir_hata),
        .veri_istek(veri_istek), .veri_yaz(veri_yaz), .veri_adres(veri_adres),
        .veri_yaz_veri(veri_yaz_veri), .veri_hazir(veri_hazir), .veri_gecerli(veri_gecerli),
        .veri_oku_veri(veri_oku_veri), .veri_hata(veri_hata),
        .bellek_adres(bellek_adres), .bellek_oku_veri(bellek_oku_veri),
        .bellek_yaz_veri(bellek_yaz_veri), .bellek_yaz(bellek_yaz)
    );

    bellek_hakem #(.OKUMA_GECIKME(3)) dut3 (
        .clk(clk), .rst(rst),
        .getir_istek(g3_getir_istek), .getir_adres(g3_getir_adres), .getir_hazir(g3_getir_hazir),
        .getir_gecerli(g3_getir_gecerli), .getir_veri(g3_getir_veri), .getir_hata(g3_getir_hata),
        .veri_istek(g3_veri_istek), .veri_yaz(g3_veri_yaz), .veri_adres(g3_veri_adres),
        .veri_yaz_veri(g3_veri_yaz_veri), .veri_hazir(g3_veri_hazir), .veri_gecerli(g3_veri_gecerli),
        .veri_oku_veri(g3_veri_oku_veri), .veri_hata(g3_veri_hata),
        .bellek_adres(g3_bellek_adres), .bellek_oku_veri(g3_bellek_oku_veri),
        .bellek_yaz_veri(g3_bellek_yaz_veri), .bellek_yaz(g3_bellek_yaz)
    );

    // Memory model: 16K words, combinational read, write on clock edge.
    logic [31:0] mem [0:16383];
    bit          init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 16384; i++) mem[i] <= {16'hA5A5, 16'(i)};
            mem[0]     <= 32'h0000_0013;
            mem[1]     <= 32'h1111_2222;
            mem[8]     <= 32'h0808_0808;
            mem[16383] <= 32'hCAFE_F00D;
            init_done  <= 1'b1;
        end else if (bellek_yaz) begin
            mem[bellek_adres[15:2]] <= bellek_yaz_veri;
        end
    end
    assign bellek_oku_veri = mem[bellek_adres[15:2]];

    // Latency-3 memory: data valid only once the address has been held 3 cycles.
    logic [31:0] g3_prev = '0;
    int          g3_held_q = 0;
    int          g3_held;
    assign g3_held = (g3_bellek_adres == g3_prev) ? g3_held_q + 1 : 1;
    always @(posedge clk) begin
        g3_prev   <= g3_bellek_adres;
        g3_held_q <= g3_held;
    end
    assign g3_bellek_oku_veri = (g3_held >= 3) ? mem[g3_bellek_adres[15:2]] : 32'hBAD0_BAD0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        g_istek;
        logic [31:0] g_adres;
        logic        v_istek;
        logic        v_yaz;
        logic [31:0] v_adres;
        logic [31:0] v_wdata;
        logic        exp_veri;
        logic        exp_hata;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_yaz;
    } vec_t;

    vec_t vecs [10];

    task automatic clear_req();
        getir_istek = 1'b0; veri_istek = 1'b0; veri_yaz = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        logic        got, win_v, nonown, resp, hata;
        logic [31:0] data;
        int          lat, yazc;
        @(posedge clk); #1;
        getir_istek = v.g_istek; getir_adres = v.g_adres;
        veri_istek = v.v_istek; veri_yaz = v.v_yaz;
        veri_adres = v.v_adres; veri_yaz_veri = v.v_wdata;
        got = 1'b0; win_v = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (getir_hazir || veri_hazir) begin
                got   = 1'b1;
                win_v = veri_hazir;
                chk({nm, "/tek_hazir"}, 32'(getir_hazir & veri_hazir), 32'd0);
            end
        end
        chk({nm, "/hazir"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        clear_req();
        if (!got) return;
        chk({nm, "/sahip"}, 32'(win_v), 32'(v.exp_veri));
        resp = 1'b0; nonown = 1'b0; hata = 1'b0; data = '0; lat = 0; yazc = 0;
        for (int k = 1; k <= 10 && !resp; k++) begin
            @(negedge clk);
            lat = k;
            if (bellek_yaz) begin
                yazc++;
                chk({nm, "/yaz_veri"}, bellek_yaz_veri, v.v_wdata);
                chk({nm, "/yaz_adres"}, bellek_adres, v.v_adres);
            end
            if (win_v) begin
                nonown = nonown | getir_gecerli | getir_hata;
                if (veri_gecerli) begin resp = 1'b1; data = veri_oku_veri; hata = veri_hata; end
            end else begin
                nonown = nonown | veri_gecerli | veri_hata;
                if (getir_gecerli) begin resp = 1'b1; data = getir_veri; hata = getir_hata; end
            end
        end
        chk({nm, "/gecerli"}, 32'(resp), 32'd1);
        chk({nm, "/gecikme"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, "/hata"}, 32'(hata), 32'(v.exp_hata));
        chk({nm, "/veri"}, data, v.exp_data);
        chk({nm, "/yaz_darbe"}, 32'(yazc), 32'(v.exp_yaz));
        chk({nm, "/diger_sessiz"}, 32'(nonown), 32'd0);
        @(negedge clk);
        chk({nm, "/tek_darbe"}, 32'(win_v ? veri_gecerli : getir_gecerli), 32'd0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        order [4];
        int          ngrant;
        logic        any;
        vec_t        v;
        logic [31:0] adr3;

        rst = 1'b1;
        clear_req();
        getir_adres = '0; veri_adres = '0; veri_yaz_veri = '0;
        g3_getir_istek = 1'b0; g3_getir_adres = '0;
        g3_veri_istek = 1'b0; g3_veri_yaz = 1'b0; g3_veri_adres = '0; g3_veri_yaz_veri = '0;

        vecs[0] = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0013, 2, 0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         2, 1};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_0010, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 2, 0};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_0002, 32'h0,         1'b1, 1'b1, 32'h0,         1, 0};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0,         1'b1, 1'b1, 32'h0,         1, 0};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h8001_0000, 32'h0,         1'b1, 1'b1, 32'h0,         1, 0};
        vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_FFFC, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D, 2, 0};
        vecs[7] = '{1'b1, 32'h8000_0001, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0,         1, 0};
        vecs[8] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0003, 32'h1234_5678, 1'b1, 1'b1, 32'h0,         1, 0};
        vecs[9] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8001_0000, 32'h5A5A_5A5A, 1'b1, 1'b1, 32'h0,         1, 0};

        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst/bellek_adres", bellek_adres, 32'h0);
        chk("rst/bellek_yaz_veri", bellek_yaz_veri, 32'h0);
        chk("rst/bellek_yaz", 32'(bellek_yaz), 32'd0);
        chk("rst/getir_cikis", {getir_veri[29:0], getir_gecerli, getir_hata}, 32'h0);
        chk("rst/veri_cikis", {veri_oku_veri[29:0], veri_gecerli, veri_hata}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("bosta/hazir_yok", 32'({getir_hazir, veri_hazir}), 32'd0);

        // ---- arbitration: both held, expect VERI, GETIR, VERI, GETIR
        @(posedge clk); #1;
        getir_istek = 1'b1; getir_adres = 32'h8000_0000;
        veri_istek = 1'b1; veri_yaz = 1'b0; veri_adres = 32'h8000_0004;
        ngrant = 0;
        for (int c = 0; c < 60 && ngrant < 4; c++) begin
            @(negedge clk);
            if (getir_hazir && veri_hazir) begin
                n_chk++; n_fail++;
                $display("FAIL hakem/iki_hazir: got both hazir high, expected at most one");
            end
            if (getir_hazir || veri_hazir) begin
                order[ngrant] = veri_hazir;
                ngrant++;
            end
        end
        @(posedge clk); #1;
        clear_req();
        chk("hakem/sayi", 32'(ngrant), 32'd4);
        if (ngrant == 4) begin
            chk("hakem/sira0", 32'(order[0]), 32'd1);
            chk("hakem/sira1", 32'(order[1]), 32'd0);
            chk("hakem/sira2", 32'(order[2]), 32'd1);
            chk("hakem/sira3", 32'(order[3]), 32'd0);
        end
        repeat (4) @(negedge clk);

        // ---- table of single transactions
        for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vek%0d", i));

        // ---- latency 3 read on second instance
        @(posedge clk); #1;
        g3_getir_istek = 1'b1; g3_getir_adres = 32'h8000_0004;
        any = 1'b0;
        for (int c = 0; c < 20 && !any; c++) begin
            @(negedge clk);
            any = g3_getir_hazir;
        end
        chk("gec3/hazir", 32'(any), 32'd1);
        @(posedge clk); #1;
        g3_getir_istek = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            adr3 = g3_bellek_adres;
            chk($sformatf("gec3/adres_T%0d", k), adr3, 32'h8000_0004);
            chk($sformatf("gec3/erken_T%0d", k), 32'(g3_getir_gecerli), 32'd0);
        end
        @(negedge clk);
        chk("gec3/gecerli_T4", 32'(g3_getir_gecerli), 32'd1);
        chk("gec3/veri", g3_getir_veri, 32'h1111_2222);
        chk("gec3/hata", 32'(g3_getir_hata), 32'd0);

        // ---- reset during YAZ
        @(posedge clk); #1;
        veri_istek = 1'b1; veri_yaz = 1'b1; veri_adres = 32'h8000_0020; veri_yaz_veri = 32'h5555_AAAA;
        any = 1'b0;
        for (int c = 0; c < 20 && !any; c++) begin
            @(negedge clk);
            any = veri_hazir;
        end
        chk("rst_yaz/hazir", 32'(any), 32'd1);
        @(posedge clk); #1;
        clear_req();
        @(negedge clk);
        chk("rst_yaz/yaz_T1", 32'(bellek_yaz), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_yaz/yaz_hemen_dustu", 32'(bellek_yaz), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        any = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any = any | veri_gecerli | getir_gecerli | bellek_yaz;
        end
        chk("rst_yaz/sessiz", 32'(any), 32'd0);
        v = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0020, 32'h0, 1'b1, 1'b0, 32'h0808_0808, 2, 0};
        run_txn(v, "rst_yaz/sonra_oku");

        // ---- reset during OKU
        @(posedge clk); #1;
        getir_istek = 1'b1; getir_adres = 32'h8000_0000;
        any = 1'b0;
        for (int c = 0; c < 20 && !any; c++) begin
            @(negedge clk);
            any = getir_hazir;
        end
        chk("rst_oku/hazir", 32'(any), 32'd1);
        @(posedge clk); #1;
        clear_req();
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        any = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any = any | veri_gecerli | getir_gecerli;
        end
        chk("rst_oku/sessiz", 32'(any), 32'd0);
        v = '{1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1111_2222, 2, 0};
        run_txn(v, "rst_oku/sonra_getir");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bellek_hakem.md
Name: bellek_hakem

Overview:
- Single-port memory arbiter and sequencer between the processor's fetch stage (getir) and its load/store stage (veri).
- Accepts one request at a time and drives the shared `bellek_*` port, which connects to `anabellek`.
- Returns read data, write acknowledgement or an access error to the winning requester.
- Replaces direct `bellek_adres`/`bellek_yaz` driving in the processor so fetch and data accesses share main memory.

Parameters:
- `VERI_BIT`, 32, data width.
- `ADRES_BIT`, 32, address width.
- `BELLEK_TABAN`, 32'h8000_0000, first valid byte address.
- `BELLEK_BOYUT`, 32'h0001_0000, memory size in bytes.
- `OKUMA_GECIKME`, 1, cycles the address must be held before `bellek_oku_veri` is valid (legal 1..4).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `getir_istek` in 1: fetch read request.
- `getir_adres` in `ADRES_BIT`: fetch address.
- `getir_hazir` out 1: fetch request accepted this cycle.
- `getir_gecerli` out 1: fetch response valid, one-cycle pulse.
- `getir_veri` out `VERI_BIT`: fetched word.
- `getir_hata` out 1: fetch access error, qualified by `getir_gecerli`.
- `veri_istek` in 1: load/store request.
- `veri_yaz` in 1: 1 = store, 0 = load.
- `veri_adres` in `ADRES_BIT`: load/store address.
- `veri_yaz_veri` in `VERI_BIT`: store data.
- `veri_hazir` out 1: load/store request accepted this cycle.
- `veri_gecerli` out 1: load/store response valid, one-cycle pulse.
- `veri_oku_veri` out `VERI_BIT`: load data.
- `veri_hata` out 1: load/store access error, qualified by `veri_gecerli`.
- `bellek_adres` out `ADRES_BIT`: memory address.
- `bellek_oku_veri` in `VERI_BIT`: memory read data.
- `bellek_yaz_veri` out `VERI_BIT`: memory write data.
- `bellek_yaz` out 1: memory write enable.

Behaviour:
- Reset (asynchronous, any cycle):
  - State goes to BOSTA; last-winner register `son_kazanan` = GETIR.
  - All outputs 0, including `bellek_adres`, `bellek_yaz_veri`, `bellek_yaz`, both `*_veri` and both `*_hata`.
  - An in-flight transaction is dropped; no `gecerli` is ever issued for it.
  - `bellek_yaz` falls immediately with reset, not at the next edge.
- Requester handshake:
  - `*_istek` and its address/data/`veri_yaz` are held stable until `*_hazir` is seen.
  - `*_hazir` is combinational, asserted only in BOSTA, and at most one `hazir` is high per cycle.
  - A requester does not re-request before its `gecerli` pulse.
- Arbitration (in BOSTA):
  - Only one requesting: it wins.
  - Both requesting: the one that is not `son_kazanan` wins (round robin). After reset, `veri` wins the first tie.
  - `son_kazanan` is updated on every grant.
- Acceptance at cycle T: the winner's address, data and write flag are latched at the end of T, as is the owner (GETIR/VERI).
- Address check at acceptance:
  - Error if `adres[1:0] != 0`, or `adres < BELLEK_TABAN`, or `adres >= BELLEK_TABAN + BELLEK_BOYUT`.
  - The comparison is done at `ADRES_BIT+1` width so the base + size sum does not wrap.
- State transitions:
  - BOSTA -> HATA_YANIT on an error.
  - BOSTA -> YAZ on a store.
  - BOSTA -> OKU on a read.
  - BOSTA -> BOSTA when no request.
- OKU:
  - `bellek_adres` = latched address for `OKUMA_GECIKME` cycles (2-bit down counter).
  - On the last cycle `bellek_oku_veri` is captured into a response register.
  - Then -> YANIT.
- YAZ (exactly one cycle):
  - `bellek_adres` = latched address, `bellek_yaz_veri` = latched data, `bellek_yaz` = 1.
  - Then -> YANIT.
- YANIT (one cycle): owner's `gecerli` = 1, `hata` = 0.
  - Load/fetch: `*_veri` = captured word.
  - Store: `*_veri` = 0.
  - Then -> BOSTA.
- HATA_YANIT (one cycle): owner's `gecerli` = 1 and `hata` = 1, `*_veri` = 0. The memory port is untouched (`bellek_yaz` stays 0). Then -> BOSTA.
- Latency from acceptance cycle T:
  - Read: `gecerli` at T+`OKUMA_GECIKME`+1.
  - Store: `bellek_yaz` at T+1, `gecerli` at T+2.
  - Error: `gecerli` at T+1.
- Timing of `*_veri`, `*_hata`, `gecerli` and the memory outputs:
  - All registered, no combinational path from `*_istek` to the memory port.
  - `bellek_adres` holds its last value in BOSTA.
  - `bellek_yaz` is 1 only in YAZ.
- The non-owner's `gecerli`/`hata` stay 0 throughout.
- A request arriving during a transaction waits; `hazir` is not asserted before the return to BOSTA.
- Back-to-back: a new grant is possible in the BOSTA cycle directly after YANIT or HATA_YANIT.

Test Plan:
- Reset, then `getir_istek` with address 0x8000_0000 (memory word 0x0000_0013), `OKUMA_GECIKME` = 1 -> `getir_hazir` at T, `getir_gecerli` at T+2 with `getir_veri` = 0x0000_0013 and `getir_hata` = 0.
- Store 0xDEAD_BEEF to 0x8000_0010, then load the same address -> `bellek_yaz` high exactly 1 cycle at T+1, `veri_gecerli` at T+2; the load returns 0xDEAD_BEEF.
- Both requests held continuously for 4 grants -> grant order VERI, GETIR, VERI, GETIR; never two `hazir` in one cycle.
- Errors: `veri_adres` = 0x8000_0002, then 0x7FFF_FFFC, then 0x8001_0000 -> each gives `veri_gecerli` and `veri_hata` at T+1 with no `bellek_yaz` pulse; 0x8000_FFFC is accepted without error.
- `OKUMA_GECIKME` = 3, read at 0x8000_0004 -> `bellek_adres` stable for 3 cycles, `getir_gecerli` at T+4 with the correct word.
- Assert `rst` during YAZ and during OKU -> `bellek_yaz` drops immediately, no `gecerli` pulse, the next request is served normally from BOSTA.
